// File: rtl/vc_dest_arbiter.sv
// rtl/vc_dest_arbiter.sv - weighted VC0/VC1 to D0/D1 word mover with almost-full back-pressure
module vc_dest_arbiter #(
  parameter int DATA_W     = 6,
  parameter int DEST_BIT   = 4,
  parameter int VC0_WEIGHT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active_in,
  input  logic              vc0_empty,
  input  logic              vc1_empty,
  input  logic [DATA_W-1:0] vc0_data,
  input  logic [DATA_W-1:0] vc1_data,
  input  logic              d0_almost_full,
  input  logic              d1_almost_full,
  output logic              vc0_pop,
  output logic              vc1_pop,
  output logic              d0_push,
  output logic              d1_push,
  output logic [DATA_W-1:0] d_data,
  output logic              last_grant,
  output logic              stall_out
);

  localparam int CNT_W = (VC0_WEIGHT < 1) ? 1 : $clog2(VC0_WEIGHT + 1);
  localparam logic [CNT_W-1:0] WCNT_MAX = CNT_W'(VC0_WEIGHT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_wcnt;
  logic                r_d0_push;
  logic                r_d1_push;
  logic [DATA_W-1:0]   r_d_data;
  logic                r_last_grant;
  logic                r_stall;

  logic                w_elig0;
  logic                w_elig1;
  logic                w_any_elig;
  logic                w_any_data;
  logic                w_vc1_turn;
  logic                w_can_grant;
  logic                w_gnt0;
  logic                w_gnt1;
  logic [DATA_W-1:0]   w_gnt_word;

  // A head word is eligible only if its destination FIFO has room.
  assign w_elig0     = !vc0_empty && !(vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full);
  assign w_elig1     = !vc1_empty && !(vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full);
  assign w_any_elig  = w_elig0 || w_elig1;
  assign w_any_data  = !vc0_empty || !vc1_empty;
  assign w_vc1_turn  = (r_wcnt == WCNT_MAX);

  // Pops are combinational; reset and a low active_in block them in the same cycle.
  assign w_can_grant = reset && active_in && (r_state == RUN);
  assign w_gnt0      = w_can_grant && w_elig0 && !(w_elig1 && w_vc1_turn);
  assign w_gnt1      = w_can_grant && w_elig1 && (!w_elig0 || w_vc1_turn);
  assign w_gnt_word  = w_gnt1 ? vc1_data : vc0_data;

  assign vc0_pop     = w_gnt0;
  assign vc1_pop     = w_gnt1;
  assign d0_push     = r_d0_push;
  assign d1_push     = r_d1_push;
  assign d_data      = r_d_data;
  assign last_grant  = r_last_grant;
  assign stall_out   = r_stall;

  // Next-state selection for the IDLE/RUN/STALL controller.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (active_in && w_any_elig)      w_next = RUN;
        else if (active_in && w_any_data) w_next = STALL;
      end
      RUN: begin
        if (!active_in || !w_any_data)    w_next = IDLE;
        else if (!w_any_elig)             w_next = STALL;
      end
      STALL: begin
        if (!active_in || !w_any_data)    w_next = IDLE;
        else if (w_any_elig)              w_next = RUN;
      end
      default: w_next = IDLE;
    endcase
  end

  // State, weight counter and the registered write side toward the D FIFOs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_wcnt       <= '0;
      r_d0_push    <= 1'b0;
      r_d1_push    <= 1'b0;
      r_d_data     <= '0;
      r_last_grant <= 1'b0;
      r_stall      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_stall   <= (w_next == STALL);
      r_d0_push <= (w_gnt0 || w_gnt1) && !w_gnt_word[DEST_BIT];
      r_d1_push <= (w_gnt0 || w_gnt1) &&  w_gnt_word[DEST_BIT];
      if (w_gnt0 || w_gnt1) begin
        r_d_data     <= w_gnt_word;
        r_last_grant <= w_gnt1;
      end
      if (w_gnt1) begin
        r_wcnt <= '0;
      end else if (w_gnt0 && !w_vc1_turn) begin
        r_wcnt <= r_wcnt + CNT_W'(1);
      end
    end
  end

endmodule
